spi_register_target: RTL and testbench

SPI_REGISTER_TARGET -- requirements
Module: spi_register_target

---
 rtl/spi_register_target.sv | 147 ++++++++++++++
 tb/tb_spi_register_target.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_target.sv
// SPI mode-0 register target: oversampled pins, opcode/operand byte decode, byte-slot MISO responses.
// Define SPI_TARGET_DOUBLE_SYNC_EN for two synchronizer flops per pin (default: one flop).
module spi_register_target #(
    parameter int OPERAND_COUNT_WIDTH = 32
) (
    input  logic                           clock_spi_in,
    input  logic                           reset_spi_in,
    input  logic                           spi_select_n_in,
    input  logic                           spi_clock_in,
    input  logic                           spi_data_in,
    output logic                           spi_data_out,
    output logic [7:0]                     op_code_out,
    output logic                           op_code_valid_out,
    output logic [7:0]                     operand_out,
    output logic                           operand_valid_out,
    output logic [OPERAND_COUNT_WIDTH-1:0] operand_count_out,
    input  logic [7:0]                     response_in,
    input  logic                           response_valid_in
);
`ifdef SPI_TARGET_DOUBLE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif
    localparam logic [1:0] WARM_CNT = 2'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sel_sync, r_sck_sync, r_mosi_sync;
    logic       r_sel_d, r_sck_d;
    logic [1:0] r_warm_cnt;
    logic       r_active, r_first, r_have_opnd, r_pend;
    logic [2:0] r_bit_cnt, r_fall_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx, r_resp;

    logic       w_sel, w_sck, w_mosi, w_warm;
    logic       w_sel_fall, w_sel_rise, w_sck_rise, w_sck_fall;
    logic [7:0] w_byte, w_resp_byte;

    assign w_sel  = r_sel_sync[SYNC_STAGES-1];
    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    // Until the delayed select copy holds real pin data, a low select is not a falling edge.
    assign w_warm     = (r_warm_cnt == WARM_CNT);
    assign w_sel_fall = r_sel_d & ~w_sel & w_warm;
    assign w_sel_rise = ~r_sel_d & w_sel;
    assign w_sck_rise = ~r_sck_d & w_sck;
    assign w_sck_fall = r_sck_d & ~w_sck;
    assign w_byte      = {r_rx, w_mosi};
    assign w_resp_byte = response_valid_in ? response_in : (r_pend ? r_resp : 8'h00);
    assign spi_data_out = r_tx[7];

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) begin
            r_sel_sync  <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_sel_d     <= 1'b1;
            r_sck_d     <= 1'b0;
            r_warm_cnt  <= 2'd0;
        end else begin
`ifdef SPI_TARGET_DOUBLE_SYNC_EN
            r_sel_sync  <= {r_sel_sync[0], spi_select_n_in};
            r_sck_sync  <= {r_sck_sync[0], spi_clock_in};
            r_mosi_sync <= {r_mosi_sync[0], spi_data_in};
`else
            r_sel_sync  <= spi_select_n_in;
            r_sck_sync  <= spi_clock_in;
            r_mosi_sync <= spi_data_in;
`endif
            r_sel_d <= w_sel;
            r_sck_d <= w_sck;
            if (!w_warm) r_warm_cnt <= r_warm_cnt + 2'd1;
        end
    end

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) begin
            r_active          <= 1'b0;
            r_first           <= 1'b0;
            r_have_opnd       <= 1'b0;
            r_pend            <= 1'b0;
            r_bit_cnt         <= 3'd0;
            r_fall_cnt        <= 3'd0;
            r_rx              <= 7'd0;
            r_tx              <= 8'h00;
            r_resp            <= 8'h00;
            op_code_out       <= 8'h00;
            op_code_valid_out <= 1'b0;
            operand_out       <= 8'h00;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
        end else begin
            if (response_valid_in) begin
                r_resp <= response_in;
                r_pend <= 1'b1;
            end
            if (w_sel_rise) begin
                r_active          <= 1'b0;
                r_bit_cnt         <= 3'd0;
                r_fall_cnt        <= 3'd0;
                r_tx              <= 8'h00;
                r_pend            <= 1'b0;
                op_code_valid_out <= 1'b0;
                operand_valid_out <= 1'b0;
                operand_count_out <= '0;
            end else if (w_sel_fall) begin
                r_active    <= 1'b1;
                r_first     <= 1'b1;
                r_have_opnd <= 1'b0;
                r_bit_cnt   <= 3'd0;
                r_fall_cnt  <= 3'd0;
                r_tx        <= 8'h00;
            end else if (r_active) begin
                if (w_sck_rise) begin
                    r_rx              <= w_byte[6:0];
                    r_bit_cnt         <= r_bit_cnt + 3'd1;
                    operand_valid_out <= 1'b0;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_first) begin
                            op_code_out       <= w_byte;
                            op_code_valid_out <= 1'b1;
                            r_first           <= 1'b0;
                        end else begin
                            operand_out       <= w_byte;
                            operand_valid_out <= 1'b1;
                            r_have_opnd       <= 1'b1;
                            if (!r_have_opnd)
                                operand_count_out <= '0;
                            else if (operand_count_out != '1)
                                operand_count_out <= operand_count_out + OPERAND_COUNT_WIDTH'(1);
                        end
                    end
                end
                if (w_sck_fall) begin
                    r_fall_cnt <= r_fall_cnt + 3'd1;
                    // Last falling edge of a slot hands the next byte's MSB to the host.
                    if (r_fall_cnt == 3'd7) begin
                        r_tx   <= w_resp_byte;
                        r_pend <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_register_target.sv
// Bench for spi_register_target: vector table, hand sequences for corner cases, randomized transactions vs a byte-level model.
module tb_spi_register_target;
    localparam int CW = 2;
`ifdef SPI_TARGET_DOUBLE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0, rst = 1'b1;
    logic          sel_n = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic          miso;
    logic [7:0]    op_code, operand, resp = 8'h00;
    logic          op_vld, opnd_vld, resp_vld = 1'b0;
    logic [CW-1:0] cnt;

    int n_chk = 0, n_bad = 0;
    bit seen_ov = 1'b0;

    spi_register_target #(.OPERAND_COUNT_WIDTH(CW)) dut (
        .clock_spi_in(clk), .reset_spi_in(rst), .spi_select_n_in(sel_n),
        .spi_clock_in(sck), .spi_data_in(mosi), .spi_data_out(miso),
        .op_code_out(op_code), .op_code_valid_out(op_vld), .operand_out(operand),
        .operand_valid_out(opnd_vld), .operand_count_out(cnt),
        .response_in(resp), .response_valid_in(resp_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (opnd_vld) seen_ov = 1'b1;

    typedef struct {
        logic [7:0] op, opnd;
        int         mode;     // 0 none, 1 one pulse, 2 two pulses, 3 pulse on the 8th falling edge
        logic [7:0] r0, r1, exp_mi1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        resp = v; resp_vld = 1'b1;
        @(negedge clk);
        resp_vld = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int mode, input logic [7:0] r0, input logic [7:0] r1,
                        output logic [7:0] mi, output logic midv);
        midv = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = miso;
            if (i == 6) midv = opnd_vld;
            sck = 1'b1;
            if (i == 4 && (mode == 1 || mode == 2)) pulse(r0);
            if (i == 2 && mode == 2) pulse(r1);
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        if (mode == 3) begin
            repeat (LAT - 1) @(negedge clk);
            pulse(r0);
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int nb);
        for (int i = 7; i >= 8 - nb; i--) begin
            mosi = v[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic sel_low();
        sel_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic sel_high();
        repeat (2) @(negedge clk);
        sel_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic int exp_cnt(input int k);
        int m = (1 << CW) - 1;
        return (k - 1 > m) ? m : k - 1;
    endfunction

    vec_t       vt[5];
    logic [7:0] mi, tmp_mi;
    logic       mv;

    initial begin
        vt[0] = '{op: 8'h21, opnd: 8'h00, mode: 1, r0: 8'h5A, r1: 8'h00, exp_mi1: 8'h5A};
        vt[1] = '{op: 8'h21, opnd: 8'h00, mode: 0, r0: 8'hEE, r1: 8'h00, exp_mi1: 8'h00};
        vt[2] = '{op: 8'h21, opnd: 8'hFF, mode: 2, r0: 8'h3C, r1: 8'hC3, exp_mi1: 8'hC3};
        vt[3] = '{op: 8'h30, opnd: 8'hA5, mode: 3, r0: 8'h77, r1: 8'h00, exp_mi1: 8'h77};
        vt[4] = '{op: 8'h2F, opnd: 8'h81, mode: 1, r0: 8'h01, r1: 8'h00, exp_mi1: 8'h01};

        #1;
        chk("reset_op_code", {24'd0, op_code}, 0);
        chk("reset_op_vld", {31'd0, op_vld}, 0);
        chk("reset_opnd", {24'd0, operand}, 0);
        chk("reset_opnd_vld", {31'd0, opnd_vld}, 0);
        chk("reset_cnt", 32'(cnt), 0);
        chk("reset_miso", {31'd0, miso}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // opcode-only transaction with exact decode latency
        seen_ov = 1'b0;
        sel_low();
        send_bits(8'h20, 7);
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("lat_before", {31'd0, op_vld}, 0);
        @(posedge clk);
        #1 chk("lat_at", {31'd0, op_vld}, 1);
        chk("lat_op", {24'd0, op_code}, 32'h20);
        @(negedge clk);
        repeat (3) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        sel_high();
        chk("op_only_vld_off", {31'd0, op_vld}, 0);
        chk("op_only_hold", {24'd0, op_code}, 32'h20);
        chk("op_only_no_opnd", {31'd0, seen_ov}, 0);

        // SCK activity while deselected is ignored
        send_bits(8'h99, 8);
        chk("desel_sck_op", {24'd0, op_code}, 32'h20);
        chk("desel_sck_vld", {31'd0, op_vld}, 0);

        // vector table: opcode + one operand, response variants
        for (int v = 0; v < 5; v++) begin
            sel_low();
            xfer(vt[v].op, vt[v].mode, vt[v].r0, vt[v].r1, mi, mv);
            chk($sformatf("v%0d_op", v), {24'd0, op_code}, {24'd0, vt[v].op});
            chk($sformatf("v%0d_op_vld", v), {31'd0, op_vld}, 1);
            chk($sformatf("v%0d_opnd_vld0", v), {31'd0, opnd_vld}, 0);
            chk($sformatf("v%0d_mi0", v), {24'd0, mi}, 0);
            xfer(vt[v].opnd, 0, 8'h00, 8'h00, mi, mv);
            chk($sformatf("v%0d_opnd", v), {24'd0, operand}, {24'd0, vt[v].opnd});
            chk($sformatf("v%0d_cnt", v), 32'(cnt), 0);
            chk($sformatf("v%0d_opnd_vld", v), {31'd0, opnd_vld}, 1);
            chk($sformatf("v%0d_mi1", v), {24'd0, mi}, {24'd0, vt[v].exp_mi1});
            sel_high();
            chk($sformatf("v%0d_end_op_vld", v), {31'd0, op_vld}, 0);
            chk($sformatf("v%0d_end_opnd_vld", v), {31'd0, opnd_vld}, 0);
            chk($sformatf("v%0d_end_miso", v), {31'd0, miso}, 0);
            chk($sformatf("v%0d_end_op_hold", v), {24'd0, op_code}, {24'd0, vt[v].op});
            chk($sformatf("v%0d_end_opnd_hold", v), {24'd0, operand}, {24'd0, vt[v].opnd});
        end

        // multi-operand stream, valid low between bytes, count saturation
        begin
            logic [7:0] seq[7] = '{8'h22, 8'hAA, 8'h55, 8'h01, 8'h10, 8'h20, 8'h30};
            sel_low();
            for (int k = 0; k < 7; k++) begin
                xfer(seq[k], 0, 8'h00, 8'h00, mi, mv);
                if (k == 0) chk("seq_op", {24'd0, op_code}, 32'h22);
                else begin
                    chk($sformatf("seq_opnd%0d", k), {24'd0, operand}, {24'd0, seq[k]});
                    chk($sformatf("seq_cnt%0d", k), 32'(cnt), 32'(exp_cnt(k)));
                    chk($sformatf("seq_vld%0d", k), {31'd0, opnd_vld}, 1);
                    chk($sformatf("seq_gap%0d", k), {31'd0, mv}, 0);
                end
            end
            sel_high();
            chk("seq_cnt_clr", 32'(cnt), 0);
        end

        // deselect part way through an operand
        sel_low();
        xfer(8'h21, 0, 8'h00, 8'h00, mi, mv);
        seen_ov = 1'b0;
        send_bits(8'hF0, 4);
        sel_high();
        chk("partial_no_vld", {31'd0, seen_ov}, 0);
        chk("partial_cnt", 32'(cnt), 0);
        sel_low();
        xfer(8'h21, 0, 8'h00, 8'h00, mi, mv);
        chk("partial_next_op", {24'd0, op_code}, 32'h21);
        chk("partial_next_vld", {31'd0, op_vld}, 1);
        sel_high();

        // reset mid-byte while MISO drives a one
        sel_low();
        xfer(8'h21, 1, 8'hFF, 8'h00, mi, mv);
        send_bits(8'h00, 3);
        chk("rst_pre_miso", {31'd0, miso}, 1);
        rst = 1'b1;
        #1;
        chk("rst_op", {24'd0, op_code}, 0);
        chk("rst_op_vld", {31'd0, op_vld}, 0);
        chk("rst_miso", {31'd0, miso}, 0);
        chk("rst_opnd", {24'd0, operand}, 0);
        @(negedge clk);
        rst = 1'b0;
        xfer(8'h20, 0, 8'h00, 8'h00, mi, mv);
        xfer(8'h20, 0, 8'h00, 8'h00, mi, mv);
        chk("rst_no_decode", {31'd0, op_vld}, 0);
        chk("rst_no_op", {24'd0, op_code}, 0);
        sel_high();
        sel_low();
        xfer(8'h20, 0, 8'h00, 8'h00, mi, mv);
        chk("rst_fresh_op", {24'd0, op_code}, 32'h20);
        chk("rst_fresh_vld", {31'd0, op_vld}, 1);
        sel_high();

        // randomized transactions against a byte-level model
        for (int t = 0; t < 12; t++) begin
            int         n;
            logic [7:0] b[8];
            logic [7:0] exp_mi[8];
            int         md[8];
            logic [7:0] ra[8], rb[8];
            n = $urandom_range(1, 7);
            exp_mi[0] = 8'h00;
            for (int k = 0; k < n; k++) begin
                b[k]  = 8'($urandom);
                md[k] = $urandom_range(0, 3);
                ra[k] = 8'($urandom);
                rb[k] = 8'($urandom);
                if (k + 1 < 8)
                    exp_mi[k+1] = (md[k] == 0) ? 8'h00 : (md[k] == 2) ? rb[k] : ra[k];
            end
            sel_low();
            for (int k = 0; k < n; k++) begin
                xfer(b[k], md[k], ra[k], rb[k], tmp_mi, mv);
                chk($sformatf("r%0d_mi%0d", t, k), {24'd0, tmp_mi}, {24'd0, exp_mi[k]});
                if (k == 0) begin
                    chk($sformatf("r%0d_op", t), {24'd0, op_code}, {24'd0, b[0]});
                    chk($sformatf("r%0d_op_vld", t), {31'd0, op_vld}, 1);
                    chk($sformatf("r%0d_ov0", t), {31'd0, opnd_vld}, 0);
                end else begin
                    chk($sformatf("r%0d_opnd%0d", t, k), {24'd0, operand}, {24'd0, b[k]});
                    chk($sformatf("r%0d_cnt%0d", t, k), 32'(cnt), 32'(exp_cnt(k)));
                    chk($sformatf("r%0d_ov%0d", t, k), {31'd0, opnd_vld}, 1);
                    chk($sformatf("r%0d_gap%0d", t, k), {31'd0, mv}, 0);
                end
            end
            sel_high();
            chk($sformatf("r%0d_end_vld", t), {31'd0, op_vld}, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
